// File: rtl/conv_engine_param_pkg.sv
// Shared types and default widths for the parametrised 1-D convolution engine.
package conv_engine_param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    ACC_LAST,
    WRITE,
    DONE
  } state_t;

  localparam logic MODE_FULL  = 1'b0;
  localparam logic MODE_VALID = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

endpackage

// File: rtl/conv_engine_param_mac.sv
// Registered multiply-accumulate; operands sign- or zero-extended by sgn, sum wraps modulo 2^ACC_WIDTH.
module conv_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        a_ext;
  logic [PW-1:0]        b_ext;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  // Extending both operands to PW first makes one unsigned multiply correct for both signednesses.
  always_comb begin
    a_ext    = {{DATA_WIDTH{sgn & a[DATA_WIDTH-1]}}, a};
    b_ext    = {{DATA_WIDTH{sgn & b[DATA_WIDTH-1]}}, b};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH-PW){sgn & prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_engine_param.sv
// 1-D convolution z = x * y over synchronous-read X/Y memories, full or valid output, writing Z.
// Each output takes T+2 cycles: T address issues, one drain cycle for the last product, one write.
module conv_engine_param
  import conv_engine_param_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH:0]   sizeX_i,
  input  logic [ADDR_WIDTH:0]   sizeY_i,
  input  logic [DATA_WIDTH-1:0] dataX_i,
  input  logic [DATA_WIDTH-1:0] dataY_i,
  output logic [ADDR_WIDTH-1:0] memXaddr_o,
  output logic [ADDR_WIDTH-1:0] memYaddr_o,
  output logic                  readXY_o,
  output logic [ADDR_WIDTH:0]   memZaddr_o,
  output logic [ACC_WIDTH-1:0]  dataZ_o,
  output logic                  writeZ_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // One extra bit over the size width so Nx+Ny-1 and m+1 never wrap.
  localparam int IW = ADDR_WIDTH + 2;
  localparam logic [IW-1:0] ONE = IW'(1);

  state_t              st;
  logic [ADDR_WIDTH:0] nx, ny, n, n_next;
  logic                mode, sgn, rd_dly;
  logic [IW-1:0]       m, k, kmax;
  logic [IW-1:0]       lz_c, m_c, kmin_c, kmax_c;
  logic [ACC_WIDTH-1:0] acc, z_hold;

  always_comb begin
    lz_c = '0;
    if (nx != '0 && ny != '0) begin
      if (mode == MODE_FULL) begin
        lz_c = IW'(nx) + IW'(ny) - ONE;
      end else if (IW'(nx) >= IW'(ny)) begin
        lz_c = IW'(nx) - IW'(ny) + ONE;
      end
    end
    n_next = (st == WRITE) ? n + 1'b1 : '0;
    m_c    = IW'(n_next) + ((mode == MODE_VALID) ? IW'(ny) - ONE : '0);
    kmin_c = (m_c + ONE > IW'(ny)) ? m_c + ONE - IW'(ny) : '0;
    kmax_c = (m_c < IW'(nx) - ONE) ? m_c : IW'(nx) - ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= IDLE;
      nx         <= '0;
      ny         <= '0;
      mode       <= MODE_FULL;
      sgn        <= 1'b0;
      n          <= '0;
      m          <= '0;
      k          <= '0;
      kmax       <= '0;
      rd_dly     <= 1'b0;
      z_hold     <= '0;
      memXaddr_o <= '0;
      memYaddr_o <= '0;
      readXY_o   <= 1'b0;
      memZaddr_o <= '0;
      writeZ_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      writeZ_o <= 1'b0;
      rd_dly   <= readXY_o;
      case (st)
        IDLE: begin
          if (start_i) begin
            nx     <= sizeX_i;
            ny     <= sizeY_i;
            mode   <= mode_i;
            sgn    <= signed_i;
            busy_o <= 1'b1;
            st     <= SETUP;
          end
        end
        SETUP, WRITE: begin
          // SETUP starts output 0; WRITE finishes output n and starts n+1.
          if (st == WRITE) begin
            z_hold <= acc;
          end
          if ((st == SETUP && lz_c == '0) || (st == WRITE && IW'(n) + ONE == lz_c)) begin
            done_o <= 1'b1;
            st     <= DONE;
          end else begin
            n          <= n_next;
            m          <= m_c;
            k          <= kmin_c;
            kmax       <= kmax_c;
            memXaddr_o <= ADDR_WIDTH'(kmin_c);
            memYaddr_o <= ADDR_WIDTH'(m_c - kmin_c);
            readXY_o   <= 1'b1;
            st         <= ISSUE;
          end
        end
        ISSUE: begin
          if (k == kmax) begin
            readXY_o <= 1'b0;
            st       <= ACC_LAST;
          end else begin
            k          <= k + ONE;
            memXaddr_o <= ADDR_WIDTH'(k + ONE);
            memYaddr_o <= ADDR_WIDTH'(m - k - ONE);
          end
        end
        ACC_LAST: begin
          writeZ_o   <= 1'b1;
          memZaddr_o <= n;
          st         <= WRITE;
        end
        DONE: begin
          busy_o <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Accumulator is final during WRITE; z_hold keeps the value visible afterwards.
  assign dataZ_o = writeZ_o ? acc : z_hold;

  conv_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .clear (st == SETUP || st == WRITE),
    .enable(rd_dly),
    .sgn   (sgn),
    .a     (dataX_i),
    .b     (dataY_i),
    .acc   (acc)
  );

endmodule

// File: tb/tb_conv_engine_param.sv
// Vector table plus write scoreboard for conv_engine_param, with start-while-busy and mid-run reset sequences.
module tb_conv_engine_param;
  import conv_engine_param_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int ZW = 2 * DW + AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          sgn_in = 1'b0;
  logic          mode_in = 1'b0;
  logic [AW:0]   nx_in = '0;
  logic [AW:0]   ny_in = '0;
  logic [DW-1:0] dx = '0;
  logic [DW-1:0] dy = '0;
  logic [AW-1:0] xaddr, yaddr;
  logic          rd, wr, busy, done;
  logic [AW:0]   zaddr;
  logic [ZW-1:0] zdat;

  always #5 clk = ~clk;

  conv_engine_param dut (
    .clk(clk), .rstn(rstn), .start_i(start), .signed_i(sgn_in), .mode_i(mode_in),
    .sizeX_i(nx_in), .sizeY_i(ny_in), .dataX_i(dx), .dataY_i(dy),
    .memXaddr_o(xaddr), .memYaddr_o(yaddr), .readXY_o(rd),
    .memZaddr_o(zaddr), .dataZ_o(zdat), .writeZ_o(wr), .busy_o(busy), .done_o(done)
  );

  logic [DW-1:0] xm [32];
  logic [DW-1:0] ym [32];

  always @(posedge clk) begin
    if (rd) begin
      dx <= xm[xaddr];
      dy <= ym[yaddr];
    end
  end

  typedef struct {
    bit            s;
    bit            md;
    int            nx;
    int            ny;
    logic [31:0]   xw;
    logic [31:0]   yw;
    bit            fill;
    int            cycles;
    int            writes;
    int            idx;
    logic [ZW-1:0] val;
  } vec_t;

  typedef struct packed {
    logic [AW:0]   a;
    logic [ZW-1:0] d;
  } wr_t;

  vec_t vt [10];
  wr_t  q [$];
  int   total = 0;
  int   bad = 0;
  int   nwr = 0;
  int   ndone = 0;
  int   cur_idx = -1;
  logic [ZW-1:0] cur_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      nwr++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0h", zaddr, zdat);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("z_addr", 64'(zaddr), 64'(e.a));
        chk("z_data", 64'(zdat), 64'(e.d));
        if (int'(zaddr) == cur_idx) chk("z_hand_value", 64'(zdat), 64'(cur_val));
      end
    end
    if (done === 1'b1) ndone++;
  end

  task automatic setv(input int i, input bit s, input bit md, input int nxv, input int nyv,
                      input logic [31:0] xw, input logic [31:0] yw, input bit fill,
                      input int cyc, input int wrs, input int idx, input logic [ZW-1:0] val);
    vt[i].s = s;   vt[i].md = md;   vt[i].nx = nxv;  vt[i].ny = nyv;
    vt[i].xw = xw; vt[i].yw = yw;   vt[i].fill = fill;
    vt[i].cycles = cyc; vt[i].writes = wrs; vt[i].idx = idx; vt[i].val = val;
  endtask

  task automatic load_and_model(input vec_t v);
    int lz;
    for (int i = 0; i < 32; i++) begin
      xm[i] = v.fill ? 8'hFF : ((i < 4) ? v.xw[8*i +: 8] : 8'h00);
      ym[i] = v.fill ? 8'hFF : ((i < 4) ? v.yw[8*i +: 8] : 8'h00);
    end
    if (v.nx == 0 || v.ny == 0) lz = 0;
    else if (!v.md) lz = v.nx + v.ny - 1;
    else lz = (v.nx >= v.ny) ? v.nx - v.ny + 1 : 0;
    for (int n = 0; n < lz; n++) begin
      longint sum;
      int mm;
      wr_t e;
      sum = 0;
      mm = n + (v.md ? v.ny - 1 : 0);
      for (int kk = 0; kk < v.nx; kk++) begin
        int j;
        longint xv, yv;
        j = mm - kk;
        if (j >= 0 && j < v.ny) begin
          xv = v.s ? longint'($signed(xm[kk])) : longint'(xm[kk]);
          yv = v.s ? longint'($signed(ym[j])) : longint'(ym[j]);
          sum += xv * yv;
        end
      end
      e.a = n[AW:0];
      e.d = sum[ZW-1:0];
      q.push_back(e);
    end
  endtask

  task automatic run(input int vi, input int restart_at);
    vec_t v;
    int cnt, nwr0, nd0;
    bit seen;
    v = vt[vi];
    load_and_model(v);
    cur_idx = v.idx;
    cur_val = v.val;
    nwr0 = nwr;
    nd0 = ndone;
    @(negedge clk);
    chk("busy_before_start", 64'(busy), 64'(0));
    start = 1'b1;
    sgn_in = v.s;
    mode_in = v.md;
    nx_in = v.nx[AW:0];
    ny_in = v.ny[AW:0];
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 3000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1) begin
        start = 1'b0;
        nx_in = '0;
        mode_in = ~mode_in;
        sgn_in = ~sgn_in;
        chk("busy_after_start", 64'(busy), 64'(1));
      end
      if (restart_at != 0 && cnt == restart_at) start = 1'b1;
      if (restart_at != 0 && cnt == restart_at + 1) start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    chk("done_cycle", 64'(cnt), 64'(v.cycles));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("busy_cleared", 64'(busy), 64'(0));
    chk("write_count", 64'(nwr - nwr0), 64'(v.writes));
    chk("done_count", 64'(ndone - nd0), 64'(1));
    chk("queue_drained", 64'(q.size()), 64'(0));
    q.delete();
    cur_idx = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr0, nd0;
    //     i  s  md nx  ny  xw            yw            fill cyc   wr  idx val
    setv(0, 0, 0, 3,  2,  32'h00030201, 32'h00000101, 0,   16,   4,  1,  21'd3);
    setv(1, 0, 1, 3,  2,  32'h00030201, 32'h00000101, 0,   10,   2,  0,  21'd3);
    setv(2, 1, 0, 2,  1,  32'h000002FF, 32'h00000003, 0,   8,    2,  0,  21'h1FFFFD);
    setv(3, 0, 0, 2,  1,  32'h000002FF, 32'h00000003, 0,   8,    2,  0,  21'd765);
    setv(4, 0, 0, 0,  2,  32'h00030201, 32'h00000101, 0,   2,    0,  -1, 21'd0);
    setv(5, 0, 1, 2,  3,  32'h00000201, 32'h00030201, 0,   2,    0,  -1, 21'd0);
    setv(6, 0, 0, 32, 32, 32'h0,        32'h0,        1,   1152, 63, 31, 21'd2080800);
    setv(7, 1, 0, 3,  2,  32'h00017F80, 32'h000080FF, 0,   16,   4,  0,  21'd128);
    setv(8, 0, 0, 3,  0,  32'h00030201, 32'h00000101, 0,   2,    0,  -1, 21'd0);
    setv(9, 0, 1, 3,  3,  32'h00030201, 32'h00060504, 0,   7,    1,  0,  21'd28);

    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_write", 64'(wr), 64'(0));
    chk("rst_read", 64'(rd), 64'(0));
    chk("rst_zdata", 64'(zdat), 64'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) run(i, 0);

    // start pulsed mid-run must not disturb the result
    run(0, 5);

    // reset in the middle of output 2's address issue
    load_and_model(vt[6]);
    @(negedge clk);
    start = 1'b1; sgn_in = 1'b0; mode_in = 1'b0; nx_in = 6'd32; ny_in = 6'd32;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_issue", 64'(rd), 64'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_read", 64'(rd), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_xaddr", 64'(xaddr), 64'(0));
    chk("mid_rst_yaddr", 64'(yaddr), 64'(0));
    chk("mid_rst_zaddr", 64'(zaddr), 64'(0));
    chk("mid_rst_zdata", 64'(zdat), 64'(0));
    chk("mid_rst_write", 64'(wr), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    q.delete();
    nwr0 = nwr;
    nd0 = ndone;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_no_writes", 64'(nwr - nwr0), 64'(0));
    chk("post_rst_no_done", 64'(ndone - nd0), 64'(0));
    run(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
